mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_ram.sv | 39 +++
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types, constants and the access-check helper for mem_responder.
// The helper is only called when MEM_RESPONDER_FAULT_EN is defined.
package mem_responder_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned or beyond the last stored word.
  function automatic logic access_fault(input logic [31:0] adr, input int unsigned depth_words);
    logic [33:0] lim;
    lim = 34'(depth_words) << 2;
    return (adr[1:0] != 2'b00) || ({2'b00, adr} >= lim);
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word storage for mem_responder: synchronous write, registered read port.
// The array itself is never reset; only the read register is.
module mem_responder_ram #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP.
// Define MEM_RESPONDER_FAULT_EN to enable misalignment/range fault checking.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 32'd1) : CNT_ZERO;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;

  logic [AW-1:0]    r_idx;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic             r_acc_fault;

  logic             w_take;
  logic             w_acc_fault;
  logic             w_enter_resp;
  logic [AW-1:0]    w_src_idx;
  logic             w_src_we;
  logic [31:0]      w_src_wdata;
  logic             w_src_fault;

  logic             w_ram_we;
  logic             w_ram_re;
  logic             w_ready_nxt;
  logic             w_fault_nxt;
  logic             r_ready;
  logic             r_fault;
  logic [31:0]      w_rdata;

  assign w_take = (r_state == IDLE) && req;

`ifdef MEM_RESPONDER_FAULT_EN
  assign w_acc_fault = access_fault(adr, DEPTH_WORDS);
`else
  assign w_acc_fault = 1'b0;
  logic w_unused_adr;
  assign w_unused_adr = ^{adr[31:AW+2], adr[1:0]};
`endif

  // With no wait states the storage access happens on the capture edge,
  // so it must see the live inputs that are being captured at that edge.
  assign w_src_idx   = (r_state == IDLE) ? adr[AW+1:2] : r_idx;
  assign w_src_we    = (r_state == IDLE) ? we          : r_we;
  assign w_src_wdata = (r_state == IDLE) ? wdata       : r_wdata;
  assign w_src_fault = (r_state == IDLE) ? w_acc_fault : r_acc_fault;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_next_state = NO_WAIT ? RESP : WAIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode: storage strobes and next values of the response flags.
  always_comb begin
    w_enter_resp = (w_next_state == RESP);
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_ready_nxt  = w_enter_resp;
    w_fault_nxt  = 1'b0;
    if (w_enter_resp && !reset) begin
      w_ram_we    = w_src_we  && !w_src_fault;
      w_ram_re    = !w_src_we && !w_src_fault;
      w_fault_nxt = w_src_fault;
    end else begin
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_fault_nxt = 1'b0;
    end
  end

  // Wait-state down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= CNT_ZERO;
    end else if (w_take && !NO_WAIT) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == WAIT) && (r_cnt != CNT_ZERO)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Request capture; later input changes cannot disturb the transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= {AW{1'b0}};
      r_we        <= 1'b0;
      r_wdata     <= 32'h0000_0000;
      r_acc_fault <= 1'b0;
    end else if (w_take) begin
      r_idx       <= adr[AW+1:2];
      r_we        <= we;
      r_wdata     <= wdata;
      r_acc_fault <= w_acc_fault;
    end else begin
      r_idx       <= r_idx;
      r_we        <= r_we;
      r_wdata     <= r_wdata;
      r_acc_fault <= r_acc_fault;
    end
  end

  // Registered response flags, high only for the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  mem_responder_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_idx   (w_src_idx),
    .i_wdata (w_src_wdata),
    .o_rdata (w_rdata)
  );

  assign rdata = w_rdata;
  assign ready = r_ready;
  assign fault = r_fault;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
// Fault-path vectors follow MEM_RESPONDER_FAULT_EN.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req0, we0, ready0, fault0;
  logic [31:0] adr0, wdata0, rdata0;
  logic        req2, we2, ready2, fault2;
  logic [31:0] adr2, wdata2, rdata2;

  int n_total;
  int n_bad;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .adr(adr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .fault(fault0)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .adr(adr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .fault(fault2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      req0 = r; we0 = w; adr0 = a; wdata0 = d;
    end else begin
      req2 = r; we2 = w; adr2 = a; wdata2 = d;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? ready0 : ready2;
  endfunction

  // One transaction: latency measured in falling edges after the request is driven.
  task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input bit scram, input logic [31:0] exp_rd, input logic exp_f,
                     input string tag);
    int          lat;
    int          exp_lat;
    logic [31:0] rd;
    logic        f;
    exp_lat = (sel == 0) ? 1 : 3;
    lat = 0;
    rd  = 32'h0;
    f   = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, w, a, d);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (scram) drive(sel, 1'b0, ~w, a ^ 32'h0000_0010, 32'h1111_1111);
        else       drive(sel, 1'b0, w, a, d);
      end
      if (get_rdy(sel)) begin
        lat = k;
        rd  = (sel == 0) ? rdata0 : rdata2;
        f   = (sel == 0) ? fault0 : fault2;
        break;
      end
    end
    chk({tag, " lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " fault"}, {31'd0, f}, {31'd0, exp_f});
    @(negedge clk);
    chk({tag, " drop"}, {31'd0, get_rdy(sel)}, 32'd0);
  endtask

  initial begin
    int   pulses, consec, first_k, last_k, gap_bad, stray;
    logic prev;
    n_total = 0;
    n_bad   = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst ready", {31'd0, ready2}, 32'd0);
    chk("rst fault", {31'd0, fault2}, 32'd0);
    chk("rst rdata", rdata2, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post rst ready", {30'd0, ready0, ready2}, 32'd0);
    chk("post rst rdata0", rdata0, 32'h0);

    // Basic write/read, then captured values immune to changes during WAIT.
    txn(2, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, "wr 10");
    txn(2, 1'b0, 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, "rd 10");
    txn(2, 1'b1, 32'h30, 32'h3030_3030, 1'b0, 32'hDEAD_BEEF, 1'b0, "wr 30");
    txn(2, 1'b1, 32'h20, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF, 1'b0, "wr 20 scram");
    txn(2, 1'b0, 32'h20, 32'h0,         1'b0, 32'hA5A5_A5A5, 1'b0, "rd 20");
    txn(2, 1'b0, 32'h30, 32'h0,         1'b0, 32'h3030_3030, 1'b0, "rd 30");

    // Continuous request: one pulse every four cycles.
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    prev = 1'b0; pulses = 0; consec = 0; first_k = 0; last_k = 0; gap_bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) req2 = 1'b0;
      if (ready2) begin
        pulses++;
        if (prev) consec++;
        if (first_k == 0) first_k = k;
        else if (k - last_k != 4) gap_bad++;
        last_k = k;
      end
      prev = ready2;
    end
    chk("stream pulses", 32'(pulses), 32'd4);
    chk("stream consec", 32'(consec), 32'd0);
    chk("stream first", 32'(first_k), 32'd3);
    chk("stream gap", 32'(gap_bad), 32'd0);
    chk("stream rdata", rdata2, 32'hDEAD_BEEF);

    // Reset while a write sits in WAIT.
    @(negedge clk);
    drive(2, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk("abort ready", {31'd0, ready2}, 32'd0);
    chk("abort rdata", rdata2, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready2) stray++;
    end
    chk("abort quiet", 32'(stray), 32'd0);
    txn(2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_A5A5, 1'b0, "rd 20 kept");

`ifdef MEM_RESPONDER_FAULT_EN
    txn(2, 1'b1, 32'h13,  32'hBADB_AD00, 1'b0, 32'hA5A5_A5A5, 1'b1, "fault wr 13");
    txn(2, 1'b0, 32'h400, 32'h0,         1'b0, 32'hA5A5_A5A5, 1'b1, "fault rd 400");
    txn(2, 1'b0, 32'h10,  32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, "rd 10 intact");
`else
    txn(2, 1'b1, 32'h000, 32'h0BAD_CAFE, 1'b0, 32'hA5A5_A5A5, 1'b0, "wr 000");
    txn(2, 1'b0, 32'h100, 32'h0,         1'b0, 32'h0BAD_CAFE, 1'b0, "wrap 100");
    txn(2, 1'b0, 32'h13,  32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, "lowbits 13");
`endif

    // Zero-wait instance: response on the cycle after the capture edge.
    txn(0, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, "w0 wr 10");
    txn(0, 1'b0, 32'h10, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, "w0 rd 10");
    txn(0, 1'b1, 32'h14, 32'h0123_4567, 1'b0, 32'hCAFE_F00D, 1'b0, "w0 wr 14");
    txn(0, 1'b0, 32'h14, 32'h0,         1'b0, 32'h0123_4567, 1'b0, "w0 rd 14");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
